// File: rtl/coin_return_ctrl_pkg.sv
// Shared defaults and state encoding for the change-return controller and
// the greedy coin selector.
package coin_return_ctrl_pkg;

    localparam int unsigned kNumCoins  = 3;
    localparam int unsigned kCoinValW  = 16;
    localparam int unsigned kNumItems  = 4;
    localparam int unsigned kTotalBits = 31;
    localparam int unsigned kTimeout   = 100;

    // Bit 0 is the smallest coin; the MSB slice is the largest.
    localparam logic [kNumCoins*kCoinValW-1:0] kCoinValues = {16'd1000, 16'd500, 16'd100};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RETURN = 2'd1,
        ST_DONE   = 2'd2
    } ret_state_e;

endpackage

// File: rtl/coin_select_greedy.sv
// Combinational greedy pick: the largest denomination that fits into
// 'remaining', as a one-hot vector plus its zero-extended value.
module coin_select_greedy
    import coin_return_ctrl_pkg::*;
#(
    parameter int unsigned NUM_COINS  = kNumCoins,
    parameter int unsigned COIN_VAL_W = kCoinValW,
    parameter int unsigned TOTAL_BITS = kTotalBits,
    parameter logic [NUM_COINS*COIN_VAL_W-1:0] COIN_VALUES = kCoinValues
) (
    input  logic [TOTAL_BITS-1:0] remaining,
    output logic [NUM_COINS-1:0]  pick_c,
    output logic                  found_c,
    output logic [TOTAL_BITS-1:0] value_c
);

    function automatic logic [TOTAL_BITS-1:0] coin_val(input int unsigned idx);
        return TOTAL_BITS'(COIN_VAL_W'(COIN_VALUES >> (idx * COIN_VAL_W)));
    endfunction

    // Ascending scan: the last fitting coin (highest index) wins.
    always_comb begin
        pick_c  = '0;
        found_c = 1'b0;
        value_c = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (coin_val(i) <= remaining) begin
                pick_c  = NUM_COINS'(1) << i;
                found_c = 1'b1;
                value_c = coin_val(i);
            end
        end
    end

endmodule

// File: rtl/coin_return_ctrl.sv
// Change-return controller: inactivity timer plus a return FSM that pays out
// the sampled balance one coin per handshake, largest denomination first.
module coin_return_ctrl
    import coin_return_ctrl_pkg::*;
#(
    parameter int unsigned NUM_COINS  = kNumCoins,
    parameter int unsigned COIN_VAL_W = kCoinValW,
    parameter logic [NUM_COINS*COIN_VAL_W-1:0] COIN_VALUES = kCoinValues,
    parameter int unsigned NUM_ITEMS  = kNumItems,
    parameter int unsigned TOTAL_BITS = kTotalBits,
    parameter int unsigned TIMEOUT    = kTimeout
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_COINS-1:0]         i_input_coin,
    input  logic [NUM_ITEMS-1:0]         i_output_item,
    input  logic                         i_trigger_return,
    input  logic [TOTAL_BITS-1:0]        i_current_total,
    output logic [NUM_COINS-1:0]         o_return_coin,
    output logic                         o_return_valid,
    input  logic                         i_return_ready,
    output logic                         o_return_done,
    output logic [TOTAL_BITS-1:0]        o_residual,
    output logic                         o_busy,
    output logic [$clog2(TIMEOUT+1)-1:0] o_wait_time
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    ret_state_e              state;
    logic [TOTAL_BITS-1:0]   remaining;
    logic [TOTAL_BITS-1:0]   offer_val;
    logic                    pending;

    logic                    coin_in_c;
    logic                    reload_c;
    logic                    expiry_c;
    logic                    start_c;
    logic                    accept_c;
    logic [TOTAL_BITS-1:0]   next_remaining_c;
    logic [NUM_COINS-1:0]    pick_c;
    logic                    found_c;
    logic [TOTAL_BITS-1:0]   pick_val_c;

    // Start/accept decode and the balance the next offer is computed from.
    always_comb begin
        coin_in_c        = |i_input_coin;
        reload_c         = coin_in_c | (|i_output_item);
        expiry_c         = (o_wait_time == TIMER_W'(1)) && !reload_c;
        start_c          = (state == ST_IDLE) && !coin_in_c &&
                           (expiry_c || i_trigger_return || pending);
        accept_c         = (state == ST_RETURN) && o_return_valid && i_return_ready;
        next_remaining_c = remaining;
        if (start_c) begin
            next_remaining_c = i_current_total;
        end else if (accept_c) begin
            next_remaining_c = remaining - offer_val;
        end
    end

    // The offer is precomputed from the post-edge balance so it can be registered.
    coin_select_greedy #(
        .NUM_COINS  (NUM_COINS),
        .COIN_VAL_W (COIN_VAL_W),
        .TOTAL_BITS (TOTAL_BITS),
        .COIN_VALUES(COIN_VALUES)
    ) u_select (
        .remaining(next_remaining_c),
        .pick_c   (pick_c),
        .found_c  (found_c),
        .value_c  (pick_val_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            remaining      <= '0;
            offer_val      <= '0;
            pending        <= 1'b0;
            o_wait_time    <= '0;
            o_return_coin  <= '0;
            o_return_valid <= 1'b0;
            o_return_done  <= 1'b0;
            o_residual     <= '0;
            o_busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state          <= ST_RETURN;
                        remaining      <= next_remaining_c;
                        offer_val      <= pick_val_c;
                        o_return_coin  <= pick_c;
                        o_return_valid <= found_c;
                        pending        <= 1'b0;
                        o_wait_time    <= '0;
                        o_busy         <= 1'b1;
                    end else begin
                        // A trigger that lost to a coin insert is served next cycle.
                        if (i_trigger_return) begin
                            pending <= 1'b1;
                        end
                        if (reload_c) begin
                            o_wait_time <= TIMER_W'(TIMEOUT);
                        end else if (o_wait_time != '0) begin
                            o_wait_time <= o_wait_time - TIMER_W'(1);
                        end
                    end
                end
                ST_RETURN: begin
                    if (!o_return_valid) begin
                        state         <= ST_DONE;
                        o_return_done <= 1'b1;
                        o_residual    <= remaining;
                    end else if (accept_c) begin
                        remaining      <= next_remaining_c;
                        offer_val      <= pick_val_c;
                        o_return_coin  <= pick_c;
                        o_return_valid <= found_c;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    o_return_done <= 1'b0;
                    o_residual    <= '0;
                    o_busy        <= 1'b0;
                    o_wait_time   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_return_ctrl.sv
// Directed and randomized bench for coin_return_ctrl: default build (a) and a
// two-coin {7,3} build (b), checked against a greedy change-making model.
module tb_coin_return_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  coin_in_a, ret_coin_a;
    logic [1:0]  coin_in_b, ret_coin_b;
    logic [3:0]  item_a, item_b;
    logic        trig_a, trig_b, ready_a, ready_b;
    logic [30:0] tot_a, tot_b, res_a, res_b;
    logic        valid_a, valid_b, done_a, done_b, busy_a, busy_b;
    logic [6:0]  wait_a;
    logic [4:0]  wait_b;

    int total_n = 0;
    int bad_n   = 0;
    bit sel     = 1'b0;

    coin_return_ctrl u_dut_a (
        .clk(clk), .reset_n(rst_n),
        .i_input_coin(coin_in_a), .i_output_item(item_a),
        .i_trigger_return(trig_a), .i_current_total(tot_a),
        .o_return_coin(ret_coin_a), .o_return_valid(valid_a),
        .i_return_ready(ready_a), .o_return_done(done_a),
        .o_residual(res_a), .o_busy(busy_a), .o_wait_time(wait_a)
    );

    coin_return_ctrl #(
        .NUM_COINS(2), .COIN_VAL_W(16), .COIN_VALUES(32'h0007_0003),
        .NUM_ITEMS(4), .TOTAL_BITS(31), .TIMEOUT(20)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_n),
        .i_input_coin(coin_in_b), .i_output_item(item_b),
        .i_trigger_return(trig_b), .i_current_total(tot_b),
        .o_return_coin(ret_coin_b), .o_return_valid(valid_b),
        .i_return_ready(ready_b), .o_return_done(done_b),
        .o_residual(res_b), .o_busy(busy_b), .o_wait_time(wait_b)
    );

    logic [2:0]  c_coin;
    logic        c_valid, c_done, c_busy;
    logic [30:0] c_res;
    assign c_coin  = sel ? {1'b0, ret_coin_b} : ret_coin_a;
    assign c_valid = sel ? valid_b : valid_a;
    assign c_done  = sel ? done_b  : done_a;
    assign c_busy  = sel ? busy_b  : busy_a;
    assign c_res   = sel ? res_b   : res_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        if (sel) ready_b = v;
        else     ready_a = v;
    endtask

    // Trigger a return on the selected DUT with the given balance.
    task automatic start_trig(input int unsigned tot);
        if (sel) begin tot_b = 31'(tot); trig_b = 1'b1; end
        else     begin tot_a = 31'(tot); trig_a = 1'b1; end
        @(negedge clk);
        trig_a = 1'b0;
        trig_b = 1'b0;
        chk("busy_after_trigger", c_busy, 1);
    endtask

    // Called on the first RETURN cycle; follows the payout against the greedy model.
    task automatic follow(input int unsigned tot, input int first_stall, input bit rand_stall);
        int unsigned vals[3];
        int          ncoins;
        int unsigned rem;
        int          q[$];
        int          found;
        int          stall;
        logic [2:0]  held;
        if (sel) begin vals = '{3, 7, 0}; ncoins = 2; end
        else     begin vals = '{100, 500, 1000}; ncoins = 3; end
        rem = tot;
        for (int g = 0; g < 64; g++) begin
            found = -1;
            for (int i = ncoins - 1; i >= 0; i--) begin
                if (found < 0 && vals[i] <= rem) found = i;
            end
            if (found < 0) break;
            q.push_back(found);
            rem -= vals[found];
        end
        for (int k = 0; k < q.size(); k++) begin
            stall = (k == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            chk("offer_valid", c_valid, 1);
            chk("offer_coin", c_coin, 64'(1) << q[k]);
            held = c_coin;
            for (int s = 0; s < stall; s++) begin
                set_ready(1'b0);
                @(negedge clk);
                chk("stall_valid", c_valid, 1);
                chk("stall_coin", c_coin, held);
            end
            set_ready(1'b1);
            @(negedge clk);
        end
        chk("no_coin_left", c_valid, 0);
        chk("done_early", c_done, 0);
        @(negedge clk);
        chk("done_pulse", c_done, 1);
        chk("residual", c_res, rem);
        chk("busy_in_done", c_busy, 1);
        @(negedge clk);
        chk("done_cleared", c_done, 0);
        chk("idle_again", c_busy, 0);
        chk("residual_cleared", c_res, 0);
        set_ready(1'b1);
    endtask

    initial begin
        int c;
        int unsigned t;
        coin_in_a = '0; coin_in_b = '0; item_a = '0; item_b = '0;
        trig_a = 1'b0; trig_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        tot_a = '0; tot_b = '0;

        #12;
        chk("rst_valid", valid_a, 0);
        chk("rst_coin", ret_coin_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_residual", res_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_wait", wait_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Inactivity timeout after a single insert.
        sel = 1'b0;
        coin_in_a = 3'b100; tot_a = 31'd1000;
        @(negedge clk);
        coin_in_a = '0;
        chk("wait_reload", wait_a, 100);
        c = 0;
        while (!busy_a && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_cycles", c, 100);
        follow(1000, 0, 0);

        // Insert in the expiry cycle cancels the timeout.
        coin_in_a = 3'b001;
        @(negedge clk);
        coin_in_a = '0;
        c = 0;
        while (wait_a != 7'd1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_wait_one", wait_a, 1);
        coin_in_a = 3'b001;
        @(negedge clk);
        coin_in_a = '0;
        chk("expiry_cancel_wait", wait_a, 100);
        chk("expiry_cancel_busy", busy_a, 0);

        // Insert coincident with trigger: start one cycle later with the new total.
        coin_in_a = 3'b010; trig_a = 1'b1; tot_a = 31'd1100;
        @(negedge clk);
        coin_in_a = '0; trig_a = 1'b0;
        chk("pending_not_busy", busy_a, 0);
        tot_a = 31'd1600;
        @(negedge clk);
        chk("pending_started", busy_a, 1);
        follow(1600, 0, 0);
        repeat (3) @(negedge clk);
        chk("timer_disarmed", wait_a, 0);

        // Stalled first offer.
        start_trig(1600);
        follow(1600, 5, 0);

        // Item dispense reloads the timer; zero balance returns nothing.
        item_a = 4'b0100;
        @(negedge clk);
        item_a = '0;
        chk("item_reload", wait_a, 100);
        start_trig(0);
        follow(0, 0, 0);

        // Custom denominations {7,3}.
        sel = 1'b1;
        start_trig(13);
        follow(13, 0, 0);
        start_trig(2);
        follow(2, 0, 0);

        // Randomized payouts on both builds.
        for (int r = 0; r < 6; r++) begin
            sel = 1'b0;
            t = $urandom_range(0, 4000);
            start_trig(t);
            follow(t, $urandom_range(0, 3), 1);
            sel = 1'b1;
            t = $urandom_range(0, 40);
            start_trig(t);
            follow(t, $urandom_range(0, 3), 1);
        end

        // Asynchronous reset in the middle of a return.
        sel = 1'b0;
        ready_a = 1'b0;
        start_trig(1600);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", valid_a, 0);
        chk("abort_coin", ret_coin_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_residual", res_a, 0);
        chk("abort_wait", wait_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", done_a, 0);
        end
        chk("idle_after_abort", busy_a, 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/coin_return_ctrl.md
Name: coin_return_ctrl

Overview:
Next-generation change-return controller for the vending machine datapath. It holds the inactivity timeout timer. It accepts an explicit return request. On timeout or request it snapshots the balance and dispenses change one coin per handshake, largest denomination first. Denomination count, coin values and timeout length are parameters. It sits between the top-level total register and the coin dispenser.

Parameters:
NUM_COINS, 3, number of coin types; bit i of every coin vector is coin i
COIN_VAL_W, 16, width of one denomination value
COIN_VALUES, {16'd1000,16'd500,16'd100}, packed denomination values; index NUM_COINS-1 is the MSB slice; must be strictly descending from MSB slice to bit 0
NUM_ITEMS, 4, number of items
TOTAL_BITS, 31, balance width
TIMEOUT, 100, inactivity reload value in cycles (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_input_coin  in  NUM_COINS  one-hot coin insert pulse
i_output_item  in  NUM_ITEMS  item dispensed pulse (any bit set = dispense)
i_trigger_return  in  1  user return request pulse
i_current_total  in  TOTAL_BITS  live balance from top level
o_return_coin  out  NUM_COINS  one-hot coin being offered
o_return_valid  out  1  o_return_coin is valid
i_return_ready  in  1  dispenser accepts the offered coin
o_return_done  out  1  one-cycle pulse; the top level loads o_residual into the total
o_residual  out  TOTAL_BITS  undispensable remainder, valid with o_return_done
o_busy  out  1  high outside IDLE; the top level must gate inserts and selections
o_wait_time  out  $clog2(TIMEOUT+1)  current timer value

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, timer=0, remaining=0, pending=0. All outputs are 0.
- States: IDLE, RETURN, DONE.
- Timer in IDLE:
  - Any i_input_coin bit or any i_output_item bit reloads the timer to TIMEOUT.
  - Otherwise, if timer>0, it decrements by 1 per cycle.
  - Expiry is a cycle where timer==1 and no reload occurs. The timer goes to 0 and a return is started.
  - The timer never wraps below 0.
- Return start (IDLE only): on expiry, or on i_trigger_return, or when pending==1.
  - If i_input_coin!=0 in the same cycle, the insert wins. Set pending=1 for i_trigger_return; treat expiry as cancelled by the reload. Start next cycle.
  - Start action: remaining <= i_current_total, timer <= 0, pending <= 0, go to RETURN.
- RETURN:
  - Combinationally select k = highest index with COIN_VALUES[k] <= remaining.
  - If such k exists: o_return_valid=1 and o_return_coin=1<<k.
  - On valid&&ready: remaining <= remaining - COIN_VALUES[k]; next coin is offered the following cycle. Throughput is 1 coin/cycle with ready held high.
  - The offered coin must stay stable while valid && !ready.
  - If no k exists (remaining < smallest value, including 0): o_return_valid=0; go to DONE.
- DONE: lasts one cycle. o_return_done=1 and o_residual=remaining. Then go to IDLE with timer=0 (disarmed until the next insert/dispense).
- In RETURN/DONE:
  - i_input_coin, i_output_item and i_trigger_return are ignored; o_busy=1.
  - i_current_total is not re-sampled.
- Reset mid-RETURN: return is aborted immediately and no done pulse is issued. Balance ownership stays with the top level.
- Arithmetic: the COIN_VALUES slice is zero-extended to TOTAL_BITS. Subtraction cannot underflow by construction.

Decomposition:
- vending_machine_def package/header: kNumCoins, kNumItems, kTotalBits defaults, default coin value vector, state encodings.
- One sub-module, coin_select_greedy: combinational, takes remaining and COIN_VALUES, gives one-hot pick and found flag. It is reused by the top-level price check.
- Timer and FSM stay in coin_return_ctrl.

Test Plan:
- Insert 1000 at t0 with no further activity, ready=1 -> return starts at t0+100. Coin 100b offered (1000) for 1 cycle, then done with residual 0.
- total=1600 and i_trigger_return, ready=1 -> coins 100b, 010b, 001b on 3 consecutive cycles. Done the next cycle, residual 0.
- total=1600, ready low for 5 cycles during the first offer -> 100b held stable 5 cycles and no decrement. Sequence then completes as above.
- Coin insert in the same cycle as the timer 1->0 -> timer reloads to 100 and no return. Insert coincident with trigger -> return starts 1 cycle later with the updated total.
- Custom params COIN_VALUES={7,3}, total=13 -> 7, 3, 3 dispensed; residual=0. Then total=2 -> immediate done, residual=2, no coins.
- reset_n low mid-RETURN (asynchronous, off clock edge) -> all outputs 0 at once. State is IDLE after release and no o_return_done pulse occurs.
